// File: rtl/echo_engine.sv
// echo_engine: per-channel feedback echo on circular delay lines.
// One sample per tick; channels are processed serially through
// RD -> CALC -> WR, then all outputs update together.
module echo_engine #(
  parameter int WIDTH     = 32,
  parameter int NCH       = 2,
  parameter int MAX_DEPTH = 8192,
  localparam int AW       = $clog2(MAX_DEPTH)
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 enable,
  input  logic [AW-1:0]        delay,
  input  logic [2:0]           fb_shift,
  input  logic [2:0]           wet_shift,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = WIDTH + 2;
  localparam logic signed [SW-1:0] SMAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {3'b111, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_CALC, S_WR, S_DONE} state_t;

  // clamp a widened sum back into the signed WIDTH range
  function automatic logic [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SMAX)      return SMAX[WIDTH-1:0];
    else if (v < SMIN) return SMIN[WIDTH-1:0];
    else               return v[WIDTH-1:0];
  endfunction

  state_t                      r_state;
  logic [AW-1:0]               r_clr_addr;
  logic [AW-1:0]               r_wr_ptr;
  logic [CW-1:0]               r_c;
  logic [NCH-1:0][WIDTH-1:0]   r_x;
  logic [AW-1:0]               r_delay;
  logic [2:0]                  r_fb;
  logic [2:0]                  r_wet;
  logic [WIDTH-1:0]            r_d;
  logic [NCH-1:0][WIDTH-1:0]   r_y;
  logic [NCH*WIDTH-1:0]        r_out_data;
  logic                        r_out_valid;
  logic                        r_overrun;
  logic                        r_en;
  logic                        r_clr_req;

  logic                        w_fall;
  logic [AW-1:0]               w_deff;
  logic [AW-1:0]               w_raddr;
  logic [2:0]                  w_fbeff;
  logic [WIDTH-1:0]            w_x;
  logic signed [SW-1:0]        w_xe;
  logic signed [SW-1:0]        w_de;
  logic signed [SW-1:0]        w_fbsum;
  logic signed [SW-1:0]        w_ysum;
  logic [WIDTH-1:0]            w_fbsat;
  logic [WIDTH-1:0]            w_ysat;
  logic [NCH-1:0]              w_we;
  logic [AW-1:0]               w_waddr;
  logic [WIDTH-1:0]            w_wdata;
  logic [NCH-1:0][WIDTH-1:0]   w_rdq;
  logic [NCH-1:0][WIDTH-1:0]   w_ynext;

  // registered enable 1 -> input 0 is a falling edge
  assign w_fall  = r_en & ~enable;
  assign w_deff  = (r_delay == '0) ? AW'(1) : r_delay;
  assign w_raddr = r_wr_ptr - w_deff;
  assign w_fbeff = (r_fb == 3'd0) ? 3'd1 : r_fb;

  assign w_x     = r_x[r_c];
  assign w_xe    = {{2{w_x[WIDTH-1]}}, w_x};
  assign w_de    = {{2{r_d[WIDTH-1]}}, r_d};
  assign w_fbsum = w_xe + (w_de >>> w_fbeff);
  assign w_ysum  = (w_xe >>> 1) + (w_de >>> r_wet);
  assign w_fbsat = sat(w_fbsum);
  assign w_ysat  = sat(w_ysum);

  assign w_waddr = (r_state == S_CLEAR) ? r_clr_addr : r_wr_ptr;
  assign w_wdata = (r_state == S_CLEAR) ? '0 : w_fbsat;

  // outputs of the last channel join the ones already computed
  always_comb begin
    w_ynext      = r_y;
    w_ynext[r_c] = w_ysat;
  end

  genvar ch;
  generate
    for (ch = 0; ch < NCH; ch++) begin : g_lane
      logic [WIDTH-1:0] r_mem [MAX_DEPTH];
      logic [WIDTH-1:0] r_q;

      assign w_we[ch]  = (r_state == S_CLEAR) ||
                         ((r_state == S_WR) && (r_c == CW'(ch)));
      assign w_rdq[ch] = r_q;

      // delay line: one write port, synchronous read at the tap address
      always_ff @(posedge CLOCK_50) begin
        if (w_we[ch]) r_mem[w_waddr] <= w_wdata;
        r_q <= r_mem[w_raddr];
      end
    end
  endgenerate

  // sample sequencer: clear, per-channel read/calc/write, publish
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_CLEAR;
      r_clr_addr  <= '0;
      r_wr_ptr    <= '0;
      r_c         <= '0;
      r_x         <= '0;
      r_delay     <= '0;
      r_fb        <= '0;
      r_wet       <= '0;
      r_d         <= '0;
      r_y         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_en        <= 1'b0;
      r_clr_req   <= 1'b0;
    end else begin
      r_en        <= enable;
      r_out_valid <= 1'b0;
      if (tick && (r_state inside {S_RD, S_CALC, S_WR, S_DONE}))
        r_overrun <= 1'b1;
      if (w_fall && (r_state inside {S_RD, S_CALC, S_WR}))
        r_clr_req <= 1'b1;
      unique case (r_state)
        S_CLEAR: begin
          if (tick) begin
            r_out_data  <= in_data;
            r_out_valid <= 1'b1;
          end
          r_clr_addr <= r_clr_addr + AW'(1);
          if (r_clr_addr == '1) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
          end
        end
        S_IDLE: begin
          if (tick && !enable) begin
            r_out_data  <= in_data;
            r_out_valid <= 1'b1;
          end else if (tick) begin
            r_x     <= in_data;
            r_delay <= delay;
            r_fb    <= fb_shift;
            r_wet   <= wet_shift;
            r_c     <= '0;
            r_state <= S_RD;
          end
          if (w_fall) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
          end
        end
        S_RD:   r_state <= S_CALC;
        S_CALC: begin
          r_d     <= w_rdq[r_c];
          r_state <= S_WR;
        end
        S_WR: begin
          r_y[r_c] <= w_ysat;
          if (r_c == CW'(NCH-1)) begin
            r_out_data  <= w_ynext;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_c     <= r_c + CW'(1);
            r_state <= S_RD;
          end
        end
        S_DONE: begin
          r_wr_ptr  <= r_wr_ptr + AW'(1);
          r_c       <= '0;
          r_clr_req <= 1'b0;
          if (r_clr_req || w_fall) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != S_IDLE);
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_echo_engine.sv
// Scoreboard bench for echo_engine: stimulus pushes expected outputs
// (from a delay-line model using plain integer math), a monitor pops
// and compares data and arrival cycle on every out_valid.
module tb_echo_engine;
  localparam int W  = 32;
  localparam int N  = 2;
  localparam int D  = 16;
  localparam int AW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           tick = 1'b0;
  logic           en = 1'b0;
  logic [AW-1:0]  dly = '0;
  logic [2:0]     fb = '0;
  logic [2:0]     wet = '0;
  logic [N*W-1:0] din = '0;
  logic [N*W-1:0] dout;
  logic           vld, busy, ovr;

  echo_engine #(.WIDTH(W), .NCH(N), .MAX_DEPTH(D)) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .tick(tick), .enable(en),
    .delay(dly), .fb_shift(fb), .wet_shift(wet), .in_data(din),
    .out_data(dout), .out_valid(vld), .busy(busy), .overrun(ovr));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nbad = 0;

  typedef struct { logic [N*W-1:0] data; int at; } exp_t;
  exp_t q[$];
  exp_t mon_e;

  longint m_buf[N][D];
  int     m_wp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint satl(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < N; c++)
      for (int a = 0; a < D; a++) m_buf[c][a] = 0;
    m_wp = 0;
  endfunction

  // one echo sample: tap = value written d_eff samples ago
  function automatic logic [N*W-1:0] model_echo(input logic [N*W-1:0] x, input int dl,
                                                input int f, input int wt);
    logic [N*W-1:0] y;
    int de, fe;
    longint xs, d;
    y  = '0;
    de = (dl == 0) ? 1 : dl;
    fe = (f == 0) ? 1 : f;
    for (int c = 0; c < N; c++) begin
      xs = longint'($signed(x[c*W +: W]));
      d  = m_buf[c][(m_wp - de + D) % D];
      m_buf[c][m_wp] = satl(xs + (d >>> fe));
      y[c*W +: W] = 32'(satl((xs >>> 1) + (d >>> wt)));
    end
    m_wp = (m_wp + 1) % D;
    return y;
  endfunction

  // kind: 0 echo, 1 bypass, 2 dropped (overrun), 3 aborted by reset
  task automatic issue(input logic [N*W-1:0] x, input int dl, input int f,
                       input int wt, input int kind);
    exp_t e;
    @(posedge clk); #1;
    din = x; dly = AW'(dl); fb = 3'(f); wet = 3'(wt); tick = 1'b1;
    if (kind == 0) begin
      e.data = model_echo(x, dl, f, wt); e.at = cyc + 7; q.push_back(e);
    end else if (kind == 1) begin
      e.data = x; e.at = cyc + 1; q.push_back(e);
    end
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    @(negedge clk);
    for (int i = 0; i < 8 && busy !== 1'b1; i++) @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    if ($urandom_range(0, 3) == 0) return W'($urandom);
    return W'(int'($urandom_range(0, 10000)) - 5000);
  endfunction

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
  endtask

  // monitor: every output pulse must match the oldest expectation
  always @(negedge clk) begin
    if (vld === 1'b1) begin
      if (q.size() == 0) begin
        nvec++; nbad++;
        $display("FAIL unexpected_out_valid: got data %h at cycle %0d, required no output", dout, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("out_data", dout, mon_e.data);
        chk("latency_cycle", 64'(cyc), 64'(mon_e.at));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [N*W-1:0] x;
    model_clear();
    repeat (2) @(posedge clk); #1;
    chk("reset_out_data", dout, 0);
    chk("reset_out_valid", 64'(vld), 0);
    chk("reset_busy", 64'(busy), 1);
    chk("reset_overrun", 64'(ovr), 0);
    rst_n = 1'b1;
    busy_len(n);
    chk("reset_clear_len", 64'(n), 16);
    en = 1'b1;
    gap(2);

    // impulse, ticks every 20 cycles
    for (int i = 0; i < 13; i++) begin
      issue((i == 0) ? 64'd1000 : 64'd0, 4, 1, 1, 0);
      gap(18);
    end
    chk("overrun_quiet", 64'(ovr), 0);

    // delay 0 acts as delay 1, impulse on ch1
    for (int i = 0; i < 4; i++) begin
      issue((i == 0) ? {32'd2000, 32'd0} : 64'd0, 0, 2, 0, 0);
      gap(7);
    end

    // randomized parameters and data
    for (int i = 0; i < 30; i++) begin
      x = {rnd(), rnd()};
      issue(x, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7), 0);
      gap($urandom_range(6, 12));
    end

    // wrap of the write pointer with the longest delay
    for (int i = 0; i < 40; i++) begin
      x = {rnd(), rnd()};
      issue(x, 15, $urandom_range(0, 7), $urandom_range(0, 3), 0);
      gap(6);
    end

    // saturation both directions
    for (int i = 0; i < 8; i++) begin
      issue({32'h0000_0000, 32'h7FFF_FFFF}, 1, 0, 0, 0);
      gap(6);
    end
    for (int i = 0; i < 8; i++) begin
      issue({32'h8000_0000, 32'h7FFF_FFFF}, 1, 0, 0, 0);
      gap(6);
    end

    // bypass and clear
    @(posedge clk); #1;
    en = 1'b0;
    fork
      busy_len(n);
      begin
        gap(3);
        issue({32'h1234_5678, 32'hCAFE_F00D}, 4, 1, 1, 1);
      end
    join
    chk("disable_clear_len", 64'(n), 16);
    model_clear();
    issue({32'hDEAD_BEEF, 32'h0BAD_F00D}, 4, 1, 1, 1);
    gap(3);
    en = 1'b1;
    gap(2);
    for (int i = 0; i < 9; i++) begin
      issue((i == 0) ? {32'd3000, 32'd1000} : 64'd0, 4, 1, 1, 0);
      gap(7);
    end

    // overrun: second tick three cycles after the first
    issue({32'd77, 32'd55}, 3, 1, 1, 0);
    @(posedge clk); #1;
    issue({32'd99, 32'd11}, 3, 1, 1, 2);
    gap(10);
    chk("overrun_set", 64'(ovr), 1);
    for (int i = 0; i < 3; i++) begin
      issue({rnd(), rnd()}, 3, 1, 1, 0);
      gap(8);
    end
    chk("overrun_sticky", 64'(ovr), 1);

    // reset in the middle of a sample
    issue({32'd500, 32'd600}, 2, 1, 1, 3);
    gap(2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_data", dout, 0);
    chk("midreset_out_valid", 64'(vld), 0);
    chk("midreset_busy", 64'(busy), 1);
    chk("midreset_overrun", 64'(ovr), 0);
    model_clear();
    gap(2); #1;
    rst_n = 1'b1;
    busy_len(n);
    chk("midreset_clear_len", 64'(n), 16);
    for (int i = 0; i < 3; i++) begin
      issue({rnd(), rnd()}, 1, 1, 1, 0);
      gap(8);
    end

    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      nvec++; nbad++;
      $display("FAIL missing_out_valid: got %0d outputs pending, required 0", q.size());
    end
    gap(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
